// File: rtl/mul_ctrl_if.sv
// mul_ctrl_if -- request/response bundle for the iterative multiplier.
//   Request : req_valid/req_ready handshake, req_op, req_rs1, req_rs2, req_tag
//   Response: resp_valid/resp_ready handshake, resp_data, resp_tag
//   Control : flush (abort in-flight op), busy (unit not idle)
// The slave modport is the multiplier side; master is the requester/consumer.
interface mul_ctrl_if #(
   parameter int TAG_W = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [31:0]      req_rs1;
   logic [31:0]      req_rs2;
   logic [TAG_W-1:0] req_tag;
   logic             flush;
   logic             resp_valid;
   logic             resp_ready;
   logic [31:0]      resp_data;
   logic [TAG_W-1:0] resp_tag;
   logic             busy;

   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush, resp_ready,
      output req_ready, resp_valid, resp_data, resp_tag, busy
   );

   modport master (
      output req_valid, req_op, req_rs1, req_rs2, req_tag, flush, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_tag, busy
   );
endinterface

// File: rtl/mul_ctrl.sv
// mul_ctrl -- iterative 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to unsigned magnitudes on acceptance, multiplied
// 4 multiplier bits per cycle over 8 CALC cycles, then the sign is applied
// to the full 64-bit product in FIX. Latency is fixed at 10 cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mul_ctrl_if.slave (request, response, flush, busy)
module mul_ctrl #(
   parameter int TAG_W = 5
) (
   input  logic        clk,
   input  logic        rst,
   mul_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_n;

   logic [63:0]      r_acc;
   logic [2:0]       r_cnt;
   logic             r_neg;
   logic [1:0]       r_op;
   logic [TAG_W-1:0] r_tag;
   logic [31:0]      r_mcand;
   logic [31:0]      r_mplier;

   logic             w_accept;
   logic             w_rs1_sgn;
   logic             w_rs2_sgn;
   logic [3:0]       w_nib;
   logic [35:0]      w_pp;
   logic [63:0]      w_pp_sh;

   // Magnitude of an operand; only taken when the operand is treated as
   // signed. 0x80000000 maps to itself, which is the correct unsigned value.
   function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   // MUL's low word is sign-agnostic, so it shares the signed x signed path.
   assign w_rs1_sgn = (bus.req_op != 2'b11);
   assign w_rs2_sgn = !bus.req_op[1];

   assign bus.req_ready = (r_state == S_IDLE) && !bus.flush;
   assign w_accept      = bus.req_valid && bus.req_ready;

   // One 32x4 partial product per cycle, placed at nibble position r_cnt.
   assign w_nib   = r_mplier[{r_cnt, 2'b00} +: 4];
   assign w_pp    = {4'b0, r_mcand} * {32'b0, w_nib};
   assign w_pp_sh = {28'b0, w_pp} << {r_cnt, 2'b00};

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      if (bus.flush) begin
         w_state_n = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_accept)          w_state_n = S_CALC;
            S_CALC: if (r_cnt == 3'd7)     w_state_n = S_FIX;
            S_FIX:                         w_state_n = S_DONE;
            S_DONE: if (bus.resp_ready)    w_state_n = S_IDLE;
            default:                       w_state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_neg <= 1'b0;
         r_op  <= '0;
         r_tag <= '0;
      end else if (w_accept) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_neg <= (w_rs1_sgn & bus.req_rs1[31]) ^ (w_rs2_sgn & bus.req_rs2[31]);
         r_op  <= bus.req_op;
         r_tag <= bus.req_tag;
      end else if (r_state == S_CALC) begin
         r_acc <= r_acc + w_pp_sh;
         r_cnt <= r_cnt + 3'd1;
      end else if (r_state == S_FIX && r_neg) begin
         r_acc <= ~r_acc + 64'd1;
      end
   end

   // Operand magnitudes carry no state worth clearing on reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mcand  <= f_mag(bus.req_rs1, w_rs1_sgn);
         r_mplier <= f_mag(bus.req_rs2, w_rs2_sgn);
      end
   end

   assign bus.busy       = (r_state != S_IDLE);
   assign bus.resp_valid = (r_state == S_DONE);
   assign bus.resp_data  = (r_state != S_DONE) ? 32'd0 :
                           (r_op == 2'b00)     ? r_acc[31:0] : r_acc[63:32];
   assign bus.resp_tag   = (r_state == S_DONE) ? r_tag : '0;

endmodule
